// File: rtl/noc_pkg.sv
// Shared NoC router definitions: packet geometry, port indices, FSM state types
// and the destination-to-output route decode.
package noc_pkg;

    localparam int WIDTH_packet = 57;
    localparam int DEST_HI      = 56;
    localparam int DEST_LO      = 53;

    localparam logic [1:0] PORT_C0     = 2'd0;
    localparam logic [1:0] PORT_C1     = 2'd1;
    localparam logic [1:0] PORT_C2     = 2'd2;
    localparam logic [1:0] PORT_PARENT = 2'd3;

    typedef enum logic {
        I_IDLE,
        I_ACK
    } in_state_t;

    typedef enum logic [1:0] {
        O_IDLE,
        O_REQ,
        O_REL
    } out_state_t;

    // Packets for another cluster go up the tree; local ones pick a child.
    function automatic logic [1:0] route_sel(input logic [3:0] dest, input logic [1:0] cluster);
        if (dest[3:2] != cluster)
            return PORT_PARENT;
        return dest[1:0];
    endfunction

    function automatic logic route_invalid(input logic [3:0] dest, input logic [1:0] cluster);
        return (dest[3:2] == cluster) && (dest[1:0] == PORT_PARENT);
    endfunction

endpackage

// File: rtl/input_ctrl_route_if.sv
// Four-phase ingress channel plus the one-hot routed egress channels.
interface input_ctrl_route_if #(
    parameter int WIDTH_packet = noc_pkg::WIDTH_packet
);
    logic                    in_req;
    logic                    in_ack;
    logic [WIDTH_packet-1:0] in_data;
    logic [3:0]              out_req;
    logic [3:0]              out_ack;
    logic [WIDTH_packet-1:0] out_data;

    modport master (
        output in_req, in_data, out_ack,
        input  in_ack, out_req, out_data
    );

    modport slave (
        input  in_req, in_data, out_ack,
        output in_ack, out_req, out_data
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers; push and pop may coincide.
module sync_fifo #(
    parameter int WIDTH = 59,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/input_ctrl_route.sv
// Router ingress: four-phase capture into a small FIFO, then in-order delivery
// of each packet on exactly one of three child outputs or the parent output.
module input_ctrl_route #(
    parameter int         WIDTH_packet = noc_pkg::WIDTH_packet,
    parameter int         DEPTH        = 2,
    parameter logic [1:0] MY_CLUSTER   = 2'd0
) (
    input  logic               clk,
    input  logic               rst_n,
    input_ctrl_route_if.slave  bus,
    output logic [7:0]         drop_count
);
    import noc_pkg::*;

    localparam int FW = WIDTH_packet + 2;

    in_state_t               in_state, in_next;
    out_state_t              out_state, out_next;
    logic [3:0]              dest;
    logic [1:0]              in_sel;
    logic                    in_invalid;
    logic                    push, pop, drop, load;
    logic                    full, empty;
    logic [FW-1:0]           head;
    logic [1:0]              cur_sel;
    logic [3:0]              out_req_q;
    logic [WIDTH_packet-1:0] out_data_q;

    assign dest       = bus.in_data[DEST_HI:DEST_LO];
    assign in_sel     = route_sel(dest, MY_CLUSTER);
    assign in_invalid = route_invalid(dest, MY_CLUSTER);

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata ({in_sel, bus.in_data}),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    // Invalid destinations are acknowledged even when full since they never occupy a slot.
    always_comb begin
        in_next = in_state;
        push    = 1'b0;
        drop    = 1'b0;
        case (in_state)
            I_IDLE: begin
                if (bus.in_req) begin
                    if (in_invalid) begin
                        drop    = 1'b1;
                        in_next = I_ACK;
                    end else if (!full) begin
                        push    = 1'b1;
                        in_next = I_ACK;
                    end
                end
            end
            I_ACK: begin
                if (!bus.in_req)
                    in_next = I_IDLE;
            end
            default: in_next = I_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_state   <= I_IDLE;
            drop_count <= 8'd0;
        end else begin
            in_state <= in_next;
            if (drop && (drop_count != 8'hFF))
                drop_count <= drop_count + 8'd1;
        end
    end

    assign bus.in_ack = (in_state == I_ACK);

    // The selected output is latched at load so the release phase survives the pop.
    always_comb begin
        out_next = out_state;
        load     = 1'b0;
        pop      = 1'b0;
        case (out_state)
            O_IDLE: begin
                if (!empty) begin
                    load     = 1'b1;
                    out_next = O_REQ;
                end
            end
            O_REQ: begin
                if (out_req_q[cur_sel] && bus.out_ack[cur_sel]) begin
                    pop      = 1'b1;
                    out_next = O_REL;
                end
            end
            O_REL: begin
                if (!bus.out_ack[cur_sel])
                    out_next = O_IDLE;
            end
            default: out_next = O_IDLE;
        endcase
    end

    // out_data is registered one cycle ahead of out_req and held until out_req falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_state  <= O_IDLE;
            out_req_q  <= 4'b0000;
            out_data_q <= '0;
            cur_sel    <= PORT_C0;
        end else begin
            out_state <= out_next;
            if (load) begin
                out_data_q <= head[WIDTH_packet-1:0];
                cur_sel    <= head[FW-1:WIDTH_packet];
            end
            if (pop)
                out_req_q <= 4'b0000;
            else if (out_state == O_REQ)
                out_req_q <= 4'b0001 << cur_sel;
        end
    end

    assign bus.out_req  = out_req_q;
    assign bus.out_data = out_data_q;

endmodule

// File: tb/tb_input_ctrl_route.sv
// Scoreboard bench: upstream driver feeds a routing model queue, a downstream
// responder pops and compares every packet the router presents.
module tb_input_ctrl_route;
    import noc_pkg::*;

    localparam int         W       = noc_pkg::WIDTH_packet;
    localparam logic [1:0] CLUSTER = 2'd0;

    typedef struct packed {
        logic [3:0]   req;
        logic [W-1:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] drop_count;

    exp_t exp_q[$];
    int   checks    = 0;
    int   failures  = 0;
    int   drop_exp  = 0;
    int   ack_delay = 2;
    bit   hold_ack  = 1'b0;

    input_ctrl_route_if #(.WIDTH_packet(W)) bus_if();

    input_ctrl_route #(
        .WIDTH_packet (W),
        .DEPTH        (2),
        .MY_CLUSTER   (CLUSTER)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus_if.slave),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    // Route rule: foreign cluster -> parent (3), local index 3 -> dropped (-1), else child index.
    function automatic int expectPort(input logic [3:0] dest);
        int d;
        d = int'(dest);
        if ((d / 4) != int'(CLUSTER))
            return 3;
        if ((d % 4) == 3)
            return -1;
        return d % 4;
    endfunction

    function automatic logic [W-1:0] makePacket(input logic [3:0] dest);
        logic [63:0]  r;
        logic [W-1:0] p;
        r = {$urandom(), $urandom()};
        p = r[W-1:0];
        p[DEST_HI:DEST_LO] = dest;
        return p;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic raiseReq(input logic [W-1:0] pkt);
        @(negedge clk);
        bus_if.in_data = pkt;
        bus_if.in_req  = 1'b1;
    endtask

    task automatic completeReq(output int latency);
        int port;
        int cnt;
        latency = 0;
        while (!bus_if.in_ack && latency < 2000) begin
            @(negedge clk);
            latency++;
        end
        if (!bus_if.in_ack) begin
            checkOutput("in_ack_timeout", 64'(bus_if.in_ack), 64'd1);
            bus_if.in_req = 1'b0;
            return;
        end
        port = expectPort(bus_if.in_data[DEST_HI:DEST_LO]);
        if (port < 0)
            drop_exp = (drop_exp < 255) ? drop_exp + 1 : 255;
        else
            exp_q.push_back('{req: 4'b0001 << port, data: bus_if.in_data});
        bus_if.in_req = 1'b0;
        cnt = 0;
        while (bus_if.in_ack && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("in_ack_release", 64'(bus_if.in_ack), 64'd0);
    endtask

    task automatic applyStimulus(input logic [W-1:0] pkt, output int latency);
        raiseReq(pkt);
        completeReq(latency);
    endtask

    task automatic waitDrain();
        int cnt;
        cnt = 0;
        while ((exp_q.size() != 0 || bus_if.out_req != 4'b0 || bus_if.out_ack != 4'b0) && cnt < 1000) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("drain", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    assert property (@(negedge clk) disable iff (!rst_n) $onehot0(bus_if.out_req))
        else begin
            failures++;
            $display("[TB] FAIL out_req_multihot: got %b, required at most one bit", bus_if.out_req);
        end

    // Downstream responder: compare on out_req rise, ack after a delay, release after out_req falls.
    initial begin
        exp_t         e;
        logic [W-1:0] cap;
        bit           stable;
        int           cnt;
        bus_if.out_ack = 4'b0;
        forever begin
            @(negedge clk);
            if (rst_n && bus_if.out_req != 4'b0) begin
                checkOutput("out_req_onehot", 64'($onehot(bus_if.out_req)), 64'd1);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_out_req: got %b, expected no request", bus_if.out_req);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("out_req", 64'(bus_if.out_req), 64'(e.req));
                    checkOutput("out_data", 64'(bus_if.out_data), 64'(e.data));
                end
                cap    = bus_if.out_data;
                stable = 1'b1;
                cnt    = 0;
                while ((hold_ack || cnt < ack_delay) && cnt < 5000) begin
                    @(negedge clk);
                    cnt++;
                    if (bus_if.out_req == 4'b0)
                        break;
                    if (bus_if.out_data !== cap)
                        stable = 1'b0;
                end
                if (bus_if.out_req != 4'b0) begin
                    bus_if.out_ack = bus_if.out_req;
                    cnt = 0;
                    while (bus_if.out_req != 4'b0 && cnt < 50) begin
                        @(negedge clk);
                        cnt++;
                        if (bus_if.out_req != 4'b0 && bus_if.out_data !== cap)
                            stable = 1'b0;
                    end
                    checkOutput("out_req_release", 64'(bus_if.out_req), 64'd0);
                end
                bus_if.out_ack = 4'b0;
                checkOutput("out_data_stable", 64'(stable), 64'd1);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int           lat;
        int           cnt;
        logic [3:0]   d;
        logic [W-1:0] p;

        rst_n          = 1'b0;
        bus_if.in_req  = 1'b0;
        bus_if.in_data = '0;
        #1;
        checkOutput("reset_in_ack", 64'(bus_if.in_ack), 64'd0);
        checkOutput("reset_out_req", 64'(bus_if.out_req), 64'd0);
        checkOutput("reset_out_data", 64'(bus_if.out_data), 64'd0);
        checkOutput("reset_drop_count", 64'(drop_count), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] child 1 delivery with delayed ack");
        ack_delay = 2;
        p = makePacket(4'b0001);
        applyStimulus(p, lat);
        checkOutput("in_ack_latency", 64'(lat), 64'd1);
        waitDrain();

        $display("[TB] parent delivery");
        applyStimulus(makePacket(4'b1000), lat);
        waitDrain();

        $display("[TB] invalid destination drop and saturation");
        applyStimulus(makePacket(4'b0011), lat);
        repeat (4) @(negedge clk);
        checkOutput("drop_count_first", 64'(drop_count), 64'(drop_exp));
        checkOutput("no_out_req_on_drop", 64'(bus_if.out_req), 64'd0);
        for (int i = 0; i < 300; i++)
            applyStimulus(makePacket(4'b0011), lat);
        repeat (2) @(negedge clk);
        checkOutput("drop_count_saturated", 64'(drop_count), 64'(drop_exp));

        $display("[TB] backpressure with full FIFO");
        hold_ack = 1'b1;
        applyStimulus(makePacket(4'b0000), lat);
        applyStimulus(makePacket(4'b0010), lat);
        raiseReq(makePacket(4'b1100));
        repeat (10) @(negedge clk);
        checkOutput("in_ack_held_when_full", 64'(bus_if.in_ack), 64'd0);
        hold_ack = 1'b0;
        completeReq(lat);
        waitDrain();

        $display("[TB] back-to-back 2,0,2 with immediate acks");
        ack_delay = 0;
        applyStimulus(makePacket(4'b0010), lat);
        applyStimulus(makePacket(4'b0000), lat);
        applyStimulus(makePacket(4'b0010), lat);
        waitDrain();

        $display("[TB] randomized traffic");
        for (int i = 0; i < 40; i++) begin
            ack_delay = $urandom_range(0, 3);
            d = 4'($urandom_range(0, 15));
            applyStimulus(makePacket(d), lat);
        end
        waitDrain();
        checkOutput("drop_count_random", 64'(drop_count), 64'(drop_exp));

        $display("[TB] asynchronous reset during output request");
        ack_delay = 2;
        hold_ack  = 1'b1;
        applyStimulus(makePacket(4'b0010), lat);
        cnt = 0;
        while (bus_if.out_req != 4'b0100 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("out_req_before_reset", 64'(bus_if.out_req), 64'b0100);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_out_req", 64'(bus_if.out_req), 64'd0);
        checkOutput("async_reset_in_ack", 64'(bus_if.in_ack), 64'd0);
        checkOutput("async_reset_drop_count", 64'(drop_count), 64'd0);
        exp_q.delete();
        drop_exp = 0;
        hold_ack = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("post_reset_out_req", 64'(bus_if.out_req), 64'd0);
        checkOutput("post_reset_in_ack", 64'(bus_if.in_ack), 64'd0);

        $display("[TB] traffic after reset");
        applyStimulus(makePacket(4'b1001), lat);
        waitDrain();
        applyStimulus(makePacket(4'b0011), lat);
        repeat (2) @(negedge clk);
        checkOutput("drop_count_after_reset", 64'(drop_count), 64'(drop_exp));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/input_ctrl_route.md
Name: input_ctrl_route

Overview:
- Ingress-side counterpart of the router's output gate: accepts packets on one four-phase req/ack/data channel and steers each to one of four output channels.
- Routing uses the packet's destination field.
- Buffers up to DEPTH packets, so the input handshake can complete while an output handshake is stalled.
- Sits between a link receiver and the per-output arbiters of a tree-topology NoC router: three child ports plus one parent port.

Parameters:
- WIDTH_packet, 57: packet width in bits.
- DEPTH, 2: FIFO entries; power of two, at least 2.
- MY_CLUSTER, 2'd0: this router's cluster id, compared against dest[3:2].

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_req  input  1  four-phase request from upstream.
- in_ack  output  1  four-phase acknowledge to upstream.
- in_data  input  WIDTH_packet  packet; dest = in_data[56:53].
- out_req  output  4  one-hot request per output (0..2 children, 3 parent).
- out_ack  input  4  per-output acknowledge.
- out_data  output  WIDTH_packet  shared data bus; valid while any out_req bit is high.
- drop_count  output  8  saturating count of packets with an invalid destination.

Behaviour:
- Reset (async assert, sync deassert): in_ack=0, out_req=4'b0, out_data=0, drop_count=0, FIFO emptied, both FSMs to idle. Reset mid-handshake simply drops the pending packet; the upstream retries.
- Input FSM, I_IDLE / I_ACK:
  - I_IDLE with in_req=1 and FIFO not full: push in_data and tag it with route sel; set in_ack=1 the next cycle; go to I_ACK.
  - I_IDLE with in_req=1 and FIFO full: hold with in_ack=0 until space appears.
  - I_ACK: hold in_ack=1 until in_req=0 is sampled, then in_ack=0 and return to I_IDLE.
  - A new packet is never captured while in_ack=1.
- Route decode (combinational, at push):
  - dest[3:2] != MY_CLUSTER gives sel=3 (parent).
  - Otherwise sel=dest[1:0].
  - dest[1:0]=3 inside the cluster is invalid: the packet is acknowledged but not pushed, and drop_count increments, saturating at 255.
- Output FSM, O_IDLE / O_REQ / O_REL:
  - O_IDLE with FIFO not empty: out_data=head packet; out_req[head_sel]=1 the next cycle; go to O_REQ. out_data is stable from the cycle before out_req rises until out_req falls.
  - O_REQ: wait for out_ack[head_sel]=1. Then out_req=0, pop the head, go to O_REL.
  - O_REL: wait for out_ack[head_sel]=0, then go to O_IDLE. Acks on non-selected outputs are ignored.
- Latency:
  - Empty FIFO: in_req rise to in_ack rise is 1 cycle.
  - Push to out_req rise is 2 cycles.
  - Minimum output handshake is 3 cycles per packet.
- Simultaneous push and pop on the same edge is legal. Count is unchanged, and pointers wrap modulo DEPTH.
- At most one out_req bit is high at any time. Packet order is preserved, including across different outputs (no bypass).

Decomposition:
- Shared package noc_pkg:
  - WIDTH_packet.
  - Dest field bit positions DEST_HI=56, DEST_LO=53.
  - Port index constants PORT_C0..PORT_C2, PORT_PARENT.
  - Enum types for the input and output FSM states.
- One natural sub-module: sync_fifo, parameterised by width and depth. It stores the packet plus the 2-bit sel and provides full/empty, push/pop, and simultaneous push/pop.

Test Plan:
- MY_CLUSTER=0; send dest=4'b0001 with out_ack responding after 2 cycles → out_req=4'b0010, out_data equals the sent packet, in_ack high 1 cycle after in_req, and the full four-phase completes on both sides.
- Send dest=4'b1000 → out_req=4'b1000 (parent).
- Send dest=4'b0011 → in_ack completes, no out_req is raised, and drop_count=1. Then send 300 such packets → drop_count saturates at 255.
- Hold out_ack=0 and send three packets → first two acknowledged, third sees in_ack stay 0. Release out_ack → the third is accepted and all three emerge in order.
- Back-to-back packets to outputs 2, 0, 2 with immediate acks → order is preserved and out_req is never multi-hot (assertion).
- Assert rst_n=0 while out_req=4'b0100 → out_req, in_ack and drop_count go to 0 asynchronously; after release the FIFO is empty and no out_req is raised.
